hash_arbiter: RTL

HASH_ARBITER -- requirements
Module: hash_arbiter

---
 rtl/hash_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hash_arbiter.sv
// hash_arbiter: shares one multi-cycle hash unit between the FIB insert path
// and the longest-prefix lookup path. Requests are arbitrated round-robin and
// only one hash operation is in flight at a time.
module hash_arbiter #(
    parameter int HASH_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ins_req,
    input  logic [63:0] ins_prefix,
    input  logic [5:0]  ins_len,
    output logic        ins_gnt,
    output logic        ins_done,
    output logic [9:0]  ins_hash,
    input  logic        lkp_req,
    input  logic [63:0] lkp_prefix,
    input  logic [5:0]  lkp_len,
    output logic        lkp_gnt,
    output logic        lkp_done,
    output logic [9:0]  lkp_hash,
    output logic [63:0] hash_prefix,
    output logic [5:0]  hash_len,
    input  logic [9:0]  hash_value,
    output logic        busy
);

    localparam logic [2:0] LAT = 3'(HASH_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    // Owner of the current (or most recent) operation; 1 = lookup path.
    // Doubles as the round-robin history, so it resets to the insert path.
    logic        win_lkp_q, win_lkp_d;
    logic [63:0] prefix_q, prefix_d;
    logic [5:0]  len_q, len_d;
    logic [9:0]  ins_hash_q, ins_hash_d;
    logic [9:0]  lkp_hash_q, lkp_hash_d;

    logic any_req;
    logic pick_lkp;
    logic capture;

    assign any_req  = ins_req | lkp_req;
    // On a tie the lookup path wins only if the insert path won last time.
    assign pick_lkp = lkp_req & (~ins_req | ~win_lkp_q);
    assign capture  = (state_q == WAIT) && (cnt_q == LAT);

    // State register with synchronous reset back to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> WAIT on any request, WAIT -> DONE once the hash is ready, DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = WAIT;
            WAIT:    if (cnt_q == LAT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the winner's operands on grant, count latency, capture result
    always_comb begin
        cnt_d      = cnt_q;
        win_lkp_d  = win_lkp_q;
        prefix_d   = prefix_q;
        len_d      = len_q;
        ins_hash_d = ins_hash_q;
        lkp_hash_d = lkp_hash_q;
        if (state_q == IDLE && any_req) begin
            cnt_d     = 3'd0;
            win_lkp_d = pick_lkp;
            prefix_d  = pick_lkp ? lkp_prefix : ins_prefix;
            len_d     = pick_lkp ? lkp_len : ins_len;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 3'd1;
            if (capture) begin
                if (win_lkp_q) begin
                    lkp_hash_d = hash_value;
                end else begin
                    ins_hash_d = hash_value;
                end
            end
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 3'd0;
            win_lkp_q  <= 1'b0;
            prefix_q   <= 64'd0;
            len_q      <= 6'd0;
            ins_hash_q <= 10'd0;
            lkp_hash_q <= 10'd0;
        end else begin
            cnt_q      <= cnt_d;
            win_lkp_q  <= win_lkp_d;
            prefix_q   <= prefix_d;
            len_q      <= len_d;
            ins_hash_q <= ins_hash_d;
            lkp_hash_q <= lkp_hash_d;
        end
    end

    // Outputs: grant pulses in the first WAIT cycle, done pulses in DONE, both to the owner only
    always_comb begin
        ins_gnt  = 1'b0;
        lkp_gnt  = 1'b0;
        ins_done = 1'b0;
        lkp_done = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    ins_gnt = ~win_lkp_q;
                    lkp_gnt = win_lkp_q;
                end
            end
            DONE: begin
                ins_done = ~win_lkp_q;
                lkp_done = win_lkp_q;
            end
            default: ;
        endcase
    end

    assign hash_prefix = prefix_q;
    assign hash_len    = len_q;
    assign ins_hash    = ins_hash_q;
    assign lkp_hash    = lkp_hash_q;

endmodule
